// File: rtl/hit_judge_pkg.sv
// Shared definitions for the hit judge: FSM state encoding and the
// default window/counter sizing used by the top level.
package hit_judge_pkg;

    // Two-state judge FSM; encoding fixed so other blocks can decode it.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // Default hit-window length in clk cycles (legal range 1..65535).
    localparam int WINDOW_CYC_DEFAULT = 25000;

    // Default width of the window counter.
    localparam int CNT_W_DEFAULT = 16;

    // Width and saturation value of the consecutive-hit counter.
    localparam int            COMBO_W   = 8;
    localparam logic [7:0]    COMBO_MAX = 8'hFF;

endpackage : hit_judge_pkg

// File: rtl/hit_judge_key_sync.sv
// Player button conditioning: two-flop synchronizer for the raw
// asynchronous key, a third flop holding the previous synchronized
// value, and a rising-edge detector between them.
module hit_judge_key_sync (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic sync3_q;

    // Synchronizer chain plus one delay stage for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
        end else begin
            sync1_q <= key_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    // A press is the cycle where the synchronized key is high but was low.
    assign key_rise_o = sync2_q & ~sync3_q;

endmodule : hit_judge_key_sync

// File: rtl/hit_judge.sv
// Rhythm-game hit judge. A note opens a window of WINDOW_CYC cycles;
// a key press inside the window is a hit, window expiry is a miss.
// A new note arriving while a window is open judges the current note
// and re-opens the window for the new one.
// Optional feature: define HIT_COMBO_EN to add the 8-bit combo port and
// its saturating consecutive-hit counter.
module hit_judge
    import hit_judge_pkg::*;
#(
    parameter int WINDOW_CYC = WINDOW_CYC_DEFAULT,
    parameter int CNT_W      = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             note_arrive,
    input  logic             key_in,
    output logic             res,
    output logic             score_en,
    output logic             miss
`ifdef HIT_COMBO_EN
    ,
    output logic [COMBO_W-1:0] combo
`endif
);

    // Counter reload value: the window spans WINDOW_CYC cycles, the last
    // of which is the one where the counter reads zero.
    localparam logic [CNT_W-1:0] WIN_LOAD = CNT_W'(WINDOW_CYC - 1);

    logic             key_rise;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             res_q;
    logic             res_d;
    logic             miss_q;
    logic             miss_d;
    logic             score_en_q;

    hit_judge_key_sync u_key_sync (
        .clk        (clk),
        .rst        (rst),
        .key_i      (key_in),
        .key_rise_o (key_rise)
    );

    // Next-state and judgement decode. A key press wins over expiry and
    // over a new note, so at most one judgement is produced per cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = 1'b0;
        miss_d  = 1'b0;
        if (!en) begin
            // Game paused: drop any open window without judging it.
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Presses here are ignored; only a note opens a window.
                    if (note_arrive) begin
                        state_d = ARMED;
                        cnt_d   = WIN_LOAD;
                    end
                end
                ARMED: begin
                    if (key_rise) begin
                        res_d = 1'b1;
                        if (note_arrive) begin
                            cnt_d = WIN_LOAD;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else if (note_arrive) begin
                        // Next note arrived before a press: current note missed.
                        miss_d = 1'b1;
                        cnt_d  = WIN_LOAD;
                    end else if (cnt_q == '0) begin
                        miss_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, window counter and registered one-cycle judgement pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            res_q      <= 1'b0;
            miss_q     <= 1'b0;
            score_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            miss_q     <= miss_d;
            score_en_q <= res_d | miss_d;
        end
    end

    assign res      = res_q;
    assign miss     = miss_q;
    assign score_en = score_en_q;

`ifdef HIT_COMBO_EN
    logic [COMBO_W-1:0] combo_q;

    // Consecutive-hit count, updated on the same edge as the res/miss pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            combo_q <= '0;
        end else if (res_d) begin
            if (combo_q != COMBO_MAX) begin
                combo_q <= combo_q + COMBO_W'(1);
            end
        end else if (miss_d) begin
            combo_q <= '0;
        end
    end

    assign combo = combo_q;
`endif

endmodule : hit_judge

// File: doc/hit_judge.md
HIT_JUDGE -- requirements
Module: hit_judge

Interface
REQ-001 Parameter WINDOW_CYC, default 25000, hit-window length in clk cycles, legal range 1..65535.
REQ-002 Parameter CNT_W, default 16, width of the window counter.
REQ-003 clk  input  1  system clock; the block has one clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  game running; when 0, the block holds IDLE and emits no judgements.
REQ-006 note_arrive  input  1  one-cycle pulse: a note enters the hit zone.
REQ-007 key_in  input  1  raw, asynchronous player button, high when pressed.
REQ-008 res  output  1  one-cycle pulse, 1 = hit; drives the score-increment select of the score updater.
REQ-009 score_en  output  1  one-cycle pulse on every judgement, hit or miss; the score register loads nextScore on it.
REQ-010 miss  output  1  one-cycle pulse on a miss judgement.
REQ-011 combo  output  8  consecutive-hit count; present only with HIT_COMBO_EN.

Function
REQ-012 key_in SHALL pass through a two-flop synchronizer, then a third flop; key_rise = sync2 & ~sync3.
REQ-013 FSM states: IDLE, ARMED.
REQ-014 IDLE + note_arrive + en -> ARMED; window counter loaded with WINDOW_CYC-1.
REQ-015 ARMED + key_rise -> hit: res=1, score_en=1 next cycle; -> IDLE.
REQ-016 ARMED + no key_rise + counter==0 -> miss: miss=1, score_en=1 next cycle; -> IDLE.
REQ-017 ARMED + neither event -> counter decrements by 1; no outputs.
REQ-018 key_rise in IDLE SHALL be ignored: no judgement, no penalty.
REQ-019 key_rise and counter==0 in the same cycle SHALL count as a hit.
REQ-020 note_arrive in ARMED without key_rise SHALL judge the current note a miss, stay ARMED and reload the counter for the new note.
REQ-021 note_arrive with key_rise in ARMED SHALL judge a hit, stay ARMED and reload the counter.
REQ-022 en=0 SHALL force IDLE next cycle, drop any open window silently and clear the outputs; the synchronizer keeps running.
REQ-023 res, miss and score_en SHALL be registered; res and miss are never high together; score_en = res | miss.
REQ-024 Latency: res rises after the 3rd rising clk edge that samples key_in high, counting the first.
REQ-025 At most one judgement per cycle; pulses last exactly one cycle.

Reset
REQ-026 rst SHALL asynchronously force: state=IDLE, counter=0, sync flops=0, res=0, miss=0, score_en=0, combo=0.
REQ-027 rst asserted mid-window SHALL discard the window with no judgement emitted.
REQ-028 The first note_arrive after rst deasserts SHALL be accepted normally.

Configuration
REQ-029 Macro HIT_COMBO_EN: when defined, the combo port and its counter exist.
REQ-030 combo increments on each hit, saturates at 255 and clears to 0 on a miss, in the same cycle as the res/miss pulse.
REQ-031 When HIT_COMBO_EN is undefined, combo is absent and the rest of the behaviour is identical.

Structure
REQ-032 A shared package holds the state encoding (IDLE=1'b0, ARMED=1'b1) and the defaults WINDOW_CYC and CNT_W.
REQ-033 One sub-module, key_sync, contains the synchronizer and rising-edge detector; everything else is flat.

Verification
REQ-034 Bench uses WINDOW_CYC=8 for all scenarios below.
REQ-035 note_arrive, key_in high 3 cycles later -> one res pulse, one score_en pulse, miss=0, combo 0->1.
REQ-036 note_arrive, key_in held low -> miss and score_en pulse exactly 8 cycles after the ARMED entry edge; res=0; combo clears to 0.
REQ-037 key_in pulses with no note pending -> res, miss and score_en stay 0 throughout.
REQ-038 Second note_arrive 4 cycles into the window, no key -> miss for note 1; key 2 cycles later -> hit for note 2.
REQ-039 rst pulsed mid-window -> all outputs 0, state IDLE, no judgement; 256 consecutive hits -> combo holds at 255.
